// File: rtl/led_pio_sequencer.sv
// Plays a CPU-programmed LED pattern table into a PIO s1 slave via single-word Avalon-MM writes.
// Optional completion interrupt is built when LED_SEQ_IRQ_EN is defined.
module led_pio_sequencer #(
  parameter int unsigned NUM_PAT = 8,
  parameter int unsigned DW      = 10,
  parameter int unsigned CNT_W   = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [4:0]    address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic          read_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic [1:0]    m_address,
  output logic          m_chipselect,
  output logic          m_write_n,
  output logic [DW-1:0] m_writedata,
  input  logic          m_waitrequest
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int unsigned IW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam int unsigned LW = IW + 1;
  localparam logic [4:0]  NumPatL = 5'(NUM_PAT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDwell = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [LW-1:0]    length_q, length_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;
  logic             stop_pend_q, stop_pend_d;
  logic [DW-1:0]    table_q [NUM_PAT];
  logic [DW-1:0]    table_d [NUM_PAT];
  logic             irq_ena_rd;

  logic          wr, rd;
  logic          ctrl_wr, start, stop;
  logic          tbl_hit;
  logic [IW-1:0] tbl_sel;
  logic [LW-1:0] idx_nxt;
  logic [CNT_W-1:0] dwell_load;

  assign wr      = chipselect && !write_n;
  assign rd      = chipselect && !read_n;
  assign ctrl_wr = wr && (address == 5'd0);
  // STOP takes priority over START when both are written together
  assign stop    = ctrl_wr && writedata[2];
  assign start   = ctrl_wr && writedata[0] && !writedata[2];
  assign tbl_hit = address[4] && ({1'b0, address[3:0]} < NumPatL);
  assign tbl_sel = address[IW-1:0];

  assign idx_nxt    = {1'b0, idx_q} + LW'(1);
  assign dwell_load = (dwell_q == '0) ? CNT_W'(1) : dwell_q;

  assign m_address    = 2'b00;
  assign m_chipselect = (state_q == StIssue);
  assign m_write_n    = (state_q != StIssue);
  assign m_writedata  = wdata_q;

`ifdef LED_SEQ_IRQ_EN
  logic irq_ena_q, irq_ena_d;

  always_comb begin
    irq_ena_d = irq_ena_q;
    if (ctrl_wr) irq_ena_d = writedata[3];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_ena_q <= 1'b0;
    else          irq_ena_q <= irq_ena_d;
  end

  assign irq_ena_rd = irq_ena_q;
  assign irq        = done_q && irq_ena_q;
`else
  assign irq_ena_rd = 1'b0;
`endif

  // Configuration registers and pattern table
  always_comb begin
    loop_d   = loop_q;
    dwell_d  = dwell_q;
    length_d = length_q;
    for (int i = 0; i < int'(NUM_PAT); i++) table_d[i] = table_q[i];
    if (ctrl_wr) loop_d = writedata[1];
    if (wr && address == 5'd2) dwell_d = writedata[CNT_W-1:0];
    if (wr && address == 5'd3) begin
      length_d = (writedata > 32'(NUM_PAT)) ? LW'(NUM_PAT) : writedata[LW-1:0];
    end
    if (wr && tbl_hit) table_d[tbl_sel] = writedata[DW-1:0];
  end

  // Sequencer FSM; pattern data is latched on entry to ISSUE so table edits never disturb it
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    stop_pend_d = stop_pend_q;

    if (wr && address == 5'd1) done_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && length_q != '0) begin
          state_d     = StIssue;
          idx_d       = '0;
          done_d      = 1'b0;
          wdata_d     = table_q[0];
          stop_pend_d = 1'b0;
        end
      end
      StIssue: begin
        if (stop) stop_pend_d = 1'b1;
        if (!m_waitrequest) begin
          if (stop || stop_pend_q) begin
            state_d     = StIdle;
            stop_pend_d = 1'b0;
          end else begin
            state_d = StDwell;
            cnt_d   = dwell_load;
          end
        end
      end
      StDwell: begin
        if (stop) begin
          state_d = StIdle;
        end else if (cnt_q <= CNT_W'(1)) begin
          if (idx_nxt < length_q) begin
            idx_d   = idx_nxt[IW-1:0];
            wdata_d = table_q[idx_nxt[IW-1:0]];
            state_d = StIssue;
          end else if (loop_q) begin
            idx_d   = '0;
            wdata_d = table_q[0];
            state_d = StIssue;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      length_q    <= '0;
      wdata_q     <= '0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      for (int i = 0; i < int'(NUM_PAT); i++) table_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      length_q    <= length_d;
      wdata_q     <= wdata_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      for (int i = 0; i < int'(NUM_PAT); i++) table_q[i] <= table_d[i];
    end
  end

  always_comb begin
    readdata = '0;
    if (rd) begin
      if (address[4]) begin
        if (tbl_hit) readdata = 32'(table_q[tbl_sel]);
      end else begin
        case (address[3:0])
          4'd0:    readdata = {28'b0, irq_ena_rd, 1'b0, loop_q, 1'b0};
          4'd1:    readdata = {24'b0, 4'(idx_q), 2'b0, done_q, (state_q != StIdle)};
          4'd2:    readdata = 32'(dwell_q);
          4'd3:    readdata = 32'(length_q);
          default: readdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed self-checking bench for led_pio_sequencer; irq checks are built with LED_SEQ_IRQ_EN.
module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [9:0]  m_writedata;
  logic        m_waitrequest = 1'b0;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc[$];
  logic [9:0] acc_dat[$];
  logic [31:0] rdv;

  led_pio_sequencer #(.NUM_PAT(8), .DW(10), .CNT_W(24)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .read_n        (read_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  // Record every accepted master write with its cycle number
  always @(posedge clk) begin
    if (m_chipselect && !m_write_n && !m_waitrequest) begin
      acc_cyc.push_back(cyc);
      acc_dat.push_back(m_writedata);
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic clear_log();
    acc_cyc.delete();
    acc_dat.delete();
  endtask

  initial begin
    // 1: reset values
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_cs", 32'(m_chipselect), 32'h0);
    check("rst_wn", 32'(m_write_n), 32'h1);
    check("rst_wdata", 32'(m_writedata), 32'h0);
    check("rst_maddr", 32'(m_address), 32'h0);
    bus_read(5'd0, rdv); check("rst_ctrl", rdv, 32'h0);
    bus_read(5'd1, rdv); check("rst_status", rdv, 32'h0);
    bus_read(5'd2, rdv); check("rst_dwell", rdv, 32'h0);
    bus_read(5'd3, rdv); check("rst_length", rdv, 32'h0);
    bus_read(5'd16, rdv); check("rst_tbl0", rdv, 32'h0);

    // 2: single pass of two patterns
    bus_write(5'd2, 32'd3);
    bus_write(5'd3, 32'd2);
    bus_write(5'd16, 32'h155);
    bus_write(5'd17, 32'h2AA);
    bus_read(5'd17, rdv); check("tbl1_rd", rdv, 32'h2AA);
    clear_log();
    bus_write(5'd0, 32'h1);
    check("t2_issue_cs", 32'(m_chipselect), 32'h1);
    check("t2_issue_data", 32'(m_writedata), 32'h155);
    repeat (20) @(negedge clk);
    check("t2_nwrites", 32'(acc_dat.size()), 32'd2);
    check("t2_data0", 32'(acc_dat[0]), 32'h155);
    check("t2_data1", 32'(acc_dat[1]), 32'h2AA);
    check("t2_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    bus_read(5'd1, rdv); check("t2_status", rdv, 32'h12);

    // 3: looping, then STOP while dwelling
    bus_write(5'd1, 32'h0);
    clear_log();
    bus_write(5'd0, 32'h3);
    bus_read(5'd0, rdv); check("t3_ctrl_rd", rdv, 32'h2);
    for (int i = 0; i < 60 && acc_dat.size() < 3; i++) @(negedge clk);
    check("t3_nwrites_pre", 32'(acc_dat.size()), 32'd3);
    bus_write(5'd0, 32'h4);
    check("t3_stop_cs", 32'(m_chipselect), 32'h0);
    repeat (20) @(negedge clk);
    check("t3_nwrites_post", 32'(acc_dat.size()), 32'd3);
    check("t3_data0", 32'(acc_dat[0]), 32'h155);
    check("t3_data1", 32'(acc_dat[1]), 32'h2AA);
    check("t3_data2", 32'(acc_dat[2]), 32'h155);
    bus_read(5'd1, rdv); check("t3_status", rdv, 32'h0);

    // 4: waitrequest stall, table edit of the in-flight entry
    bus_write(5'd3, 32'd1);
    bus_write(5'd2, 32'd2);
    bus_write(5'd16, 32'h0F0);
    clear_log();
    m_waitrequest = 1'b1;
    bus_write(5'd0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_cs", 32'(m_chipselect), 32'h1);
      check("t4_hold_data", 32'(m_writedata), 32'h0F0);
      @(negedge clk);
    end
    bus_write(5'd16, 32'h3FF);
    check("t4_hold_wn", 32'(m_write_n), 32'h0);
    check("t4_data_kept", 32'(m_writedata), 32'h0F0);
    check("t4_none_acc", 32'(acc_dat.size()), 32'd0);
    m_waitrequest = 1'b0;
    @(negedge clk);
    check("t4_dwell_cs", 32'(m_chipselect), 32'h0);
    check("t4_one_acc", 32'(acc_dat.size()), 32'd1);
    check("t4_acc_data", 32'(acc_dat[0]), 32'h0F0);
    bus_read(5'd1, rdv); check("t4_busy", rdv, 32'h1);
    repeat (6) @(negedge clk);
    bus_read(5'd1, rdv); check("t4_done", rdv, 32'h2);

    // 5: LENGTH=0 blocks START; LENGTH clamps; unmapped reads
    bus_write(5'd1, 32'h0);
    bus_write(5'd3, 32'd0);
    clear_log();
    bus_write(5'd0, 32'h1);
    check("t5_no_cs", 32'(m_chipselect), 32'h0);
    bus_read(5'd1, rdv); check("t5_status", rdv, 32'h0);
    repeat (4) @(negedge clk);
    check("t5_no_acc", 32'(acc_dat.size()), 32'd0);
    bus_write(5'd3, 32'd20);
    bus_read(5'd3, rdv); check("t5_len_clamp", rdv, 32'd8);
    bus_read(5'd5, rdv); check("t5_unmapped", rdv, 32'h0);
    bus_read(5'd24, rdv); check("t5_tbl_oob", rdv, 32'h0);

    // 6: completion interrupt
`ifdef LED_SEQ_IRQ_EN
    bus_write(5'd3, 32'd2);
    bus_write(5'd2, 32'd3);
    bus_write(5'd16, 32'h155);
    bus_write(5'd0, 32'h9);
    bus_read(5'd0, rdv); check("t6_ctrl_rd", rdv, 32'h8);
    check("t6_irq_busy", 32'(irq), 32'h0);
    repeat (20) @(negedge clk);
    check("t6_irq_done", 32'(irq), 32'h1);
    bus_write(5'd1, 32'h0);
    check("t6_irq_clr", 32'(irq), 32'h0);
`else
    bus_write(5'd0, 32'h8);
    bus_read(5'd0, rdv); check("t6_ctrl_b3", rdv, 32'h0);
`endif

    // Asynchronous reset while a write is stalled
    bus_write(5'd3, 32'd1);
    m_waitrequest = 1'b1;
    bus_write(5'd0, 32'h1);
    check("rst_mid_cs_pre", 32'(m_chipselect), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_cs", 32'(m_chipselect), 32'h0);
    check("rst_mid_wn", 32'(m_write_n), 32'h1);
    check("rst_mid_data", 32'(m_writedata), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    bus_read(5'd3, rdv); check("rst_mid_len", rdv, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
